pt_mem_responder: RTL and testbench
===================================

Name: pt_mem_responder

Overview:
- Memory-side responder for the page-table walker's memory interface. It accepts single-word read requests on a valid/ready request channel and returns the data word on a valid/ready response channel.
- Backed by a 1024-word page-table RAM covering byte addresses 0x0000-0x0FFF, with a programmable read latency.
- A side-band init write port lets the testbench or boot logic preload page tables.
- One read is outstanding at a time, matching the walker's strict request→response sequencing.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the RAM (power of two).
- READ_LATENCY, 2, cycles from request handshake to mem_resp_valid_o assertion (legal range 1-15).
- LFSR_SEED, 16'hACE1, reset seed of the stall LFSR (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_req_valid_i  in  1  read request valid
- mem_req_ready_o  out  1  read request ready
- mem_addr_i  in  32  byte address of the request
- mem_resp_valid_o  out  1  read response valid
- mem_resp_ready_i  in  1  read response ready
- mem_data_o  out  32  read data
- init_we_i  in  1  preload write enable
- init_addr_i  in  10  preload word index
- init_data_i  in  32  preload data
- req_count_o  out  16  accepted-request counter (wraps)

Behaviour:
- Reset is synchronous and active-high on clk. Reset does not clear RAM contents.
- Reset values:
  - mem_resp_valid_o=0, mem_data_o=0, req_count_o=0
  - state=IDLE, latency counter=0, latched address=0
  - mem_req_ready_o reads 1 in the first cycle after reset unless init_we_i=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_req_ready_o = !init_we_i (combinational). The preload write has priority.
  - On handshake (valid & ready): latch mem_addr_i, load counter with READ_LATENCY-1, increment req_count_o, go to WAIT.
- WAIT:
  - mem_req_ready_o=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: read the RAM word, register it into mem_data_o, set mem_resp_valid_o=1, go to RESP.
  - Net effect: mem_resp_valid_o rises exactly READ_LATENCY cycles after the request handshake edge.
- RESP:
  - mem_req_ready_o=0.
  - mem_data_o and mem_resp_valid_o are held stable until mem_resp_ready_i=1.
  - On response handshake: clear mem_resp_valid_o, return to IDLE. The next request can be accepted no earlier than the following cycle.
- Address decode:
  - Word index = mem_addr_i[11:2]; bits [1:0] are ignored (misaligned addresses round down).
  - If mem_addr_i >= MEM_WORDS*4, the response data is 32'h0 (an invalid PTE). The RAM is not accessed.
- Init writes:
  - Accepted in any state and written on the rising edge.
  - A write to the same word in the cycle the RAM is read returns the OLD data (read-before-write).
  - A write earlier during WAIT is visible to the pending read.
- mem_req_valid_i while not in IDLE is ignored; the request is not latched.
- mem_resp_ready_i while mem_resp_valid_o=0 has no effect.
- Reset mid-WAIT/RESP: the pending response is dropped and the block resumes accepting in the next cycle.
- req_count_o wraps from 16'hFFFF to 0.

Optional Feature:
- Macro: PT_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with LFSR_SEED advances every cycle.
  - In IDLE, mem_req_ready_o = !init_we_i & lfsr[0], creating pseudo-random request backpressure.
  - On a handshake in IDLE, the extra WAIT latency added is lfsr[2:1] (0-3 cycles).
- Undefined: there is no LFSR, ready follows the IDLE rule above, and latency is exactly READ_LATENCY.

Decomposition:
- Package pt_mem_pkg:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - PT_MEM_WORDS=1024, PT_WORD_AW=10
  - PT_INVALID_PTE=32'h0
  - SATP base constant 32'h0400, shared with the walker
- Sub-module pt_mem_array: 1R1W synchronous RAM with a registered read and read-before-write on address collision. It is instantiated once.

Test Plan:
1. Preload word 256 with 32'h0000_0801, request addr 0x400 with READ_LATENCY=2 → mem_resp_valid_o rises 2 cycles after the handshake, data=0x0000_0801, req_count_o=1.
2. Hold mem_resp_ready_i=0 for 5 cycles in RESP → data and valid stay stable, mem_req_ready_o=0. Assert ready → valid drops on the next edge, and ready_o returns to 1 one cycle later.
3. Request addr 0x1000 and addr 0x0403 → first returns 32'h0; second returns the word-256 contents (low bits ignored).
4. Two-level walk driven by the walker RTL, with L1 entry word 256=0x0000_0C01 and L2 entry word 768 (vpn0=0)=0x0001_2007 → walker returns PTE 0x0001_2007; req_count_o=2.
5. Assert rst during WAIT → valid stays 0, no response is emitted, and the next request completes with correct data. Also assert init_we_i in IDLE → ready_o=0 that cycle.
6. With PT_MEM_RANDOM_STALL_EN, run 200 random requests → every response matches the preload image, no response is lost or duplicated, and latency is within READ_LATENCY..READ_LATENCY+3.

Source files
------------

// File: rtl/pt_mem_pkg.sv
// Shared constants and types for the page-table memory responder and the walker
// that talks to it.
package pt_mem_pkg;

  localparam int unsigned PT_MEM_WORDS   = 1024;
  localparam int unsigned PT_WORD_AW     = 10;
  localparam logic [31:0] PT_INVALID_PTE = 32'h0;
  localparam logic [31:0] PT_SATP_BASE   = 32'h0000_0400;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } pt_mem_state_e;

endpackage

// File: rtl/pt_mem_responder_if.sv
// Walker <-> page-table memory request/response channels (valid/ready both ways).
interface pt_mem_responder_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_data;

  modport master (
    output mem_req_valid, mem_addr, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_data
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_data
  );

endinterface

// File: rtl/pt_mem_array.sv
// 1R1W synchronous page-table RAM with a registered read port.
// A same-address write in the read cycle returns the old word.
module pt_mem_array import pt_mem_pkg::*; #(
  parameter int unsigned Words = PT_MEM_WORDS,
  parameter int unsigned Aw    = $clog2(Words)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [Words];
  logic [31:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pt_mem_responder.sv
// Page-table memory responder: one outstanding read with programmable latency.
// Define PT_MEM_RANDOM_STALL_EN for LFSR-driven request backpressure and extra latency.
module pt_mem_responder import pt_mem_pkg::*; #(
  parameter int unsigned MEM_WORDS    = PT_MEM_WORDS,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  pt_mem_responder_if.slave     mem_io,
  input  logic                  init_we_i,
  input  logic [PT_WORD_AW-1:0] init_addr_i,
  input  logic [31:0]           init_data_i,
  output logic [15:0]           req_count_o
);

  localparam int unsigned Aw        = $clog2(MEM_WORDS);
  localparam logic [31:0] ByteLimit = 32'(MEM_WORDS * 4);

  if (READ_LATENCY < 1 || READ_LATENCY > 15 || LFSR_SEED == 16'h0) begin : gen_cfg_error
    $error("pt_mem_responder: READ_LATENCY must be 1-15 and LFSR_SEED nonzero");
  end

  pt_mem_state_e state_q;
  logic [4:0]    cnt_q;
  logic [31:0]   addr_q;
  logic          resp_valid_q;
  logic          oob_q;
  logic [15:0]   req_count_q;

  logic          stall_ok;
  logic [4:0]    lat_load;
  logic          req_ready;
  logic          req_hs;
  logic          addr_oob;
  logic          rd_en;
  logic [31:0]   ram_rdata;
  logic          unused_addr_lsb;

`ifdef PT_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign stall_ok = lfsr_q[0];
  assign lat_load = 5'(READ_LATENCY - 1) + 5'(lfsr_q[2:1]);
`else
  assign stall_ok = 1'b1;
  assign lat_load = 5'(READ_LATENCY - 1);
`endif

  // Preload writes win over new requests.
  assign req_ready = (state_q == StIdle) & ~init_we_i & stall_ok;
  assign req_hs    = mem_io.mem_req_valid & req_ready;
  assign addr_oob  = addr_q >= ByteLimit;
  assign rd_en     = (state_q == StWait) && (cnt_q == 5'd0) && !addr_oob;

  assign unused_addr_lsb = ^addr_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      oob_q        <= 1'b0;
      req_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_hs) begin
            addr_q      <= mem_io.mem_addr;
            cnt_q       <= lat_load;
            req_count_q <= req_count_q + 16'd1;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 5'd0) begin
            resp_valid_q <= 1'b1;
            oob_q        <= addr_oob;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StResp: begin
          if (mem_io.mem_resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pt_mem_array #(
    .Words(MEM_WORDS),
    .Aw   (Aw)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .re_i   (rd_en),
    .raddr_i(addr_q[Aw+1:2]),
    .rdata_o(ram_rdata),
    .we_i   (init_we_i),
    .waddr_i(init_addr_i[Aw-1:0]),
    .wdata_i(init_data_i)
  );

  assign mem_io.mem_req_ready  = req_ready;
  assign mem_io.mem_resp_valid = resp_valid_q;
  assign mem_io.mem_data       = oob_q ? PT_INVALID_PTE : ram_rdata;
  assign req_count_o           = req_count_q;

endmodule

// File: tb/tb_pt_mem_responder.sv
// Randomized self-checking bench for pt_mem_responder against an array model
// of the page-table image, with directed walk, reset and backpressure cases.
module tb_pt_mem_responder;
  import pt_mem_pkg::*;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_we;
  logic [9:0]  init_addr;
  logic [31:0] init_data;
  logic [15:0] req_count;

  always #5 clk = ~clk;

  pt_mem_responder_if mif ();

  pt_mem_responder #(
    .MEM_WORDS   (1024),
    .READ_LATENCY(Lat),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_io     (mif),
    .init_we_i  (init_we),
    .init_addr_i(init_addr),
    .init_data_i(init_data),
    .req_count_o(req_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] snap;
  logic [31:0] pend_addr = '0;
  logic [15:0] exp_count = '0;

  // Model: snap is what a read of pend_addr sees at an edge (before that edge's write).
  always @(posedge clk) begin
    snap <= (pend_addr >= 32'h1000) ? PT_INVALID_PTE : ref_mem[pend_addr[11:2]];
    if (init_we) ref_mem[init_addr] <= init_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: no writes, 1: random writes, 2: rewrite the requested word every cycle
  task automatic drive_noise(input int mode, input logic [31:0] addr);
    if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
      init_we   = 1'b1;
      init_addr = (mode == 2 || $urandom_range(0, 1) == 1) ? addr[11:2] : 10'($urandom);
      init_data = $urandom;
    end else begin
      init_we = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, input int mode,
                         output logic [31:0] rdata);
    bit          hs;
    bit          got;
    int          waited;
    int          lat;
    logic [31:0] exp_d;
    pend_addr          = addr;
    mif.mem_addr       = addr;
    mif.mem_req_valid  = 1'b1;
    mif.mem_resp_ready = 1'b0;
    init_we            = 1'b0;
    hs                 = 1'b0;
    waited             = 0;
    while (!hs && waited < 64) begin
      #1 hs = mif.mem_req_ready;
      @(negedge clk);
      waited++;
    end
    check_eq("req_accept", 32'(hs), 32'd1);
    mif.mem_req_valid = 1'b0;
    mif.mem_addr      = $urandom;
    if (hs) exp_count++;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      drive_noise(mode, addr);
      @(negedge clk);
      lat++;
      got = mif.mem_resp_valid;
    end
    check_eq("resp_seen", 32'(got), 32'd1);
`ifdef PT_MEM_RANDOM_STALL_EN
    check_eq("latency_range", 32'(lat >= Lat && lat <= Lat + 3), 32'd1);
`else
    check_eq("latency", 32'(lat), 32'(Lat));
`endif
    exp_d = snap;
    rdata = mif.mem_data;
    check_eq("resp_data", mif.mem_data, exp_d);
    check_eq("req_count", 32'(req_count), 32'(exp_count));
    for (int h = 0; h < hold; h++) begin
      drive_noise(mode, addr);
      @(negedge clk);
      check_eq("hold_valid", 32'(mif.mem_resp_valid), 32'd1);
      check_eq("hold_data", mif.mem_data, exp_d);
      check_eq("hold_req_ready", 32'(mif.mem_req_ready), 32'd0);
    end
    init_we            = 1'b0;
    mif.mem_resp_ready = 1'b1;
    @(negedge clk);
    check_eq("valid_drop", 32'(mif.mem_resp_valid), 32'd0);
    mif.mem_resp_ready = 1'b0;
`ifndef PT_MEM_RANDOM_STALL_EN
    #1 check_eq("ready_return", 32'(mif.mem_req_ready), 32'd1);
`endif
  endtask

  task automatic write_word(input logic [9:0] idx, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = idx;
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    exp_count = '0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] pte;
    logic [31:0] a;
    bit          spurious;
    rst                = 1'b1;
    init_we            = 1'b0;
    init_addr          = '0;
    init_data          = '0;
    mif.mem_req_valid  = 1'b0;
    mif.mem_addr       = '0;
    mif.mem_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(mif.mem_resp_valid), 32'd0);
    check_eq("rst_data", mif.mem_data, 32'h0);
    check_eq("rst_count", 32'(req_count), 32'd0);
    check_eq("rst_ready", 32'(mif.mem_req_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 1024; i++) write_word(10'(i), $urandom);
    write_word(10'd256, 32'h0000_0801);

    // Basic read, long hold, out-of-range and misaligned addresses
    do_read(32'h0000_0400, 0, 0, rd);
    check_eq("t1_data", rd, 32'h0000_0801);
    check_eq("t1_count", 32'(req_count), 32'd1);
    do_read(32'h0000_0400, 5, 0, rd);
    do_read(32'h0000_1000, 1, 0, rd);
    check_eq("oob_data", rd, 32'h0);
    do_read(32'h0000_0403, 0, 0, rd);
    check_eq("misalign_data", rd, 32'h0000_0801);
    do_read(32'h0000_0404, 2, 2, rd);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h0FFF));
      do_read(a, $urandom_range(0, 3), $urandom_range(0, 2), rd);
    end

    // Two-level walk from the SATP base
    apply_reset();
    write_word(10'd256, 32'h0000_0C01);
    write_word(10'd768, 32'h0001_2007);
    do_read(PT_SATP_BASE + 32'(0 * 4), 0, 0, pte);
    do_read({pte[31:10], 10'b0} + 32'(0 * 4), 0, 0, pte);
    check_eq("walk_pte", pte, 32'h0001_2007);
    check_eq("walk_count", 32'(req_count), 32'd2);

    // Reset while a read is pending drops it
    mif.mem_addr      = 32'h0000_0C00;
    mif.mem_req_valid = 1'b1;
    pend_addr         = 32'h0000_0C00;
    #1 check_eq("pre_rst_ready", 32'(mif.mem_req_ready), 32'd1);
    @(negedge clk);
    mif.mem_req_valid = 1'b0;
    rst               = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    exp_count = '0;
    #1;
    check_eq("rst_wait_count", 32'(req_count), 32'd0);
    check_eq("rst_wait_ready", 32'(mif.mem_req_ready), 32'd1);
    spurious = 1'b0;
    for (int k = 0; k < Lat + 4; k++) begin
      @(negedge clk);
      if (mif.mem_resp_valid) spurious = 1'b1;
    end
    check_eq("rst_wait_no_resp", 32'(spurious), 32'd0);
    do_read(32'h0000_0C00, 0, 0, rd);
    check_eq("post_rst_data", rd, 32'h0001_2007);

    // Preload write blocks request acceptance in IDLE
    init_we   = 1'b1;
    init_addr = 10'd5;
    init_data = 32'hDEAD_BEEF;
    #1 check_eq("init_blocks_ready", 32'(mif.mem_req_ready), 32'd0);
    @(negedge clk);
    init_we = 1'b0;
    do_read(32'h0000_0014, 0, 0, rd);
    check_eq("init_word", rd, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
